// File: rtl/zap_thumb_fetch_sequencer.sv
// Fetch sequencer feeding the Thumb decompressor: one word request in flight, one word buffered,
// and one ARM word or Thumb halfword presented per accepted cycle.
module zap_thumb_fetch_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_cpsr_t,
   input  logic        i_clear,
   input  logic [31:0] i_clear_pc,
   input  logic        i_stall,
   output logic        o_fetch_req,
   output logic [31:0] o_fetch_addr,
   input  logic        i_fetch_ack,
   input  logic [31:0] i_fetch_data,
   input  logic        i_fetch_abort,
   output logic [31:0] o_instruction,
   output logic        o_instruction_valid,
   output logic        o_iabort,
   output logic [31:0] o_pc_ff,
   output logic [31:0] o_pc_plus_8_ff
);

   typedef enum logic [1:0] {FETCH, HOLD, DRAIN, STOP} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] buf_data;
   logic        buf_abort;
   logic [31:0] emit_pc;
   logic        outstanding;

   assign o_fetch_addr = {pc[31:2], 2'b00};

   // ARM entries always report the word address; a redirect with bit 1 set is word-aligned here.
   always_comb begin
      emit_pc     = i_cpsr_t ? pc : {pc[31:2], 2'b00};
      outstanding = ((state == FETCH) && o_fetch_req) || (state == DRAIN);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state               <= FETCH;
         pc                  <= RESET_VECTOR;
         buf_data            <= '0;
         buf_abort           <= 1'b0;
         o_fetch_req         <= 1'b0;
         o_instruction       <= '0;
         o_instruction_valid <= 1'b0;
         o_iabort            <= 1'b0;
         o_pc_ff             <= '0;
         o_pc_plus_8_ff      <= '0;
      end else if (i_clear) begin
         o_instruction_valid <= 1'b0;
         o_iabort            <= 1'b0;
         buf_abort           <= 1'b0;
         pc                  <= i_clear_pc & ~32'd1;
         // A request still in flight must have its ack swallowed before refetching.
         if (outstanding && !i_fetch_ack) begin
            state       <= DRAIN;
            o_fetch_req <= 1'b0;
         end else begin
            state       <= FETCH;
            o_fetch_req <= 1'b1;
         end
      end else begin
         case (state)
            FETCH: begin
               if (!i_stall) o_instruction_valid <= 1'b0;
               if (!o_fetch_req) begin
                  o_fetch_req <= 1'b1;
               end else if (i_fetch_ack) begin
                  buf_data    <= i_fetch_data;
                  buf_abort   <= i_fetch_abort;
                  o_fetch_req <= 1'b0;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (!i_stall) begin
                  o_instruction_valid <= 1'b1;
                  o_pc_ff             <= emit_pc;
                  o_pc_plus_8_ff      <= emit_pc + (i_cpsr_t ? 32'd4 : 32'd8);
                  if (buf_abort) begin
                     o_iabort      <= 1'b1;
                     o_instruction <= '0;
                     state         <= STOP;
                  end else if (i_cpsr_t) begin
                     o_iabort      <= 1'b0;
                     o_instruction <= pc[1] ? {16'd0, buf_data[31:16]} : {16'd0, buf_data[15:0]};
                     pc            <= pc + 32'd2;
                     if (pc[1]) begin
                        state       <= FETCH;
                        o_fetch_req <= 1'b1;
                     end
                  end else begin
                     o_iabort      <= 1'b0;
                     o_instruction <= buf_data;
                     pc            <= emit_pc + 32'd4;
                     state         <= FETCH;
                     o_fetch_req   <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (!i_stall) o_instruction_valid <= 1'b0;
               if (i_fetch_ack) begin
                  state       <= FETCH;
                  o_fetch_req <= 1'b1;
               end
            end
            default: begin
               if (!i_stall) o_instruction_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zap_thumb_fetch_sequencer.sv
// Directed + randomized bench: a bus responder model with random latency feeds the DUT and an
// instruction-stream model (next pc, mode, memory image) predicts every accepted entry.
module tb_zap_thumb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset, cpsr_t, clear, stall, ack, fabort;
   logic [31:0] clear_pc, fdata;
   logic        req, valid, iabort;
   logic [31:0] addr, instr, pc_out, pc8_out;

   int checks = 0;
   int errors = 0;

   // stream model
   logic [31:0] m_pc;
   logic        m_t;
   bit          m_stopped;
   int unsigned acc = 0;

   // bus responder
   bit          pend;
   logic [31:0] paddr;
   int unsigned wcnt, lat_lo, lat_hi, stall_pct;
   bit          abort_en;
   logic [31:0] abort_addr;

   zap_thumb_fetch_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
      .i_clk(clk), .i_reset(reset), .i_cpsr_t(cpsr_t), .i_clear(clear), .i_clear_pc(clear_pc),
      .i_stall(stall), .o_fetch_req(req), .o_fetch_addr(addr), .i_fetch_ack(ack),
      .i_fetch_data(fdata), .i_fetch_abort(fabort), .o_instruction(instr),
      .o_instruction_valid(valid), .o_iabort(iabort), .o_pc_ff(pc_out), .o_pc_plus_8_ff(pc8_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memw(input logic [31:0] a);
      case (a)
         32'h0000_0000: memw = 32'hE3A0_0001;
         32'h0000_0004: memw = 32'hE3A0_1002;
         32'h0000_0100: memw = 32'h4770_2001;
         default:       memw = (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compare the entry being accepted this cycle against the stream model.
   task automatic score();
      logic [31:0] wa, w, e_pc, e_ins;
      logic        ab;
      if (m_stopped) begin
         chk("no_entry_after_abort", {31'd0, valid}, 32'd0);
      end else begin
         wa    = {m_pc[31:2], 2'b00};
         w     = memw(wa);
         ab    = abort_en && (wa == abort_addr);
         e_pc  = m_t ? m_pc : wa;
         e_ins = ab ? 32'd0 : (!m_t ? w : (m_pc[1] ? {16'd0, w[31:16]} : {16'd0, w[15:0]}));
         chk("instruction", instr, e_ins);
         chk("pc", pc_out, e_pc);
         chk("pc_plus_8", pc8_out, e_pc + (m_t ? 32'd4 : 32'd8));
         chk("iabort", {31'd0, iabort}, {31'd0, ab});
         if (ab) m_stopped = 1'b1;
         m_pc = e_pc + (m_t ? 32'd2 : 32'd4);
         acc++;
      end
   endtask

   task automatic drive_cycle(input bit sc);
      stall  = ($urandom_range(99, 0) < stall_pct);
      ack    = 1'b0;
      fabort = 1'b0;
      fdata  = '0;
      if (!pend && req) begin
         pend  = 1'b1;
         paddr = addr;
         wcnt  = $urandom_range(lat_hi, lat_lo);
         chk("fetch_addr_aligned", {30'd0, addr[1:0]}, 32'd0);
      end else if (pend && req) begin
         chk("fetch_addr_stable", addr, paddr);
      end
      if (pend) begin
         if (wcnt == 0) begin
            ack    = 1'b1;
            fdata  = memw(paddr);
            fabort = abort_en && (paddr == abort_addr);
            pend   = 1'b0;
         end else begin
            wcnt--;
         end
      end
      if (sc && valid && !stall) score();
      step();
   endtask

   task automatic run_entries(input int unsigned n, input int unsigned budget);
      int unsigned start = acc;
      int unsigned k = 0;
      while ((acc - start) < n && k < budget) begin
         drive_cycle(1'b1);
         k++;
      end
      chk("entries_within_budget", acc - start, n);
   endtask

   task automatic redirect(input logic [31:0] target, input logic t);
      clear    = 1'b1;
      clear_pc = target;
      cpsr_t   = t;
      drive_cycle(1'b0);
      clear    = 1'b0;
      chk("valid_after_clear", {31'd0, valid}, 32'd0);
      chk("iabort_after_clear", {31'd0, iabort}, 32'd0);
      m_pc      = target & ~32'd1;
      m_t       = t;
      m_stopped = 1'b0;
   endtask

   task automatic wait_req(input logic [31:0] exp_addr);
      int unsigned k = 0;
      while (!req && k < 30) begin
         drive_cycle(1'b1);
         k++;
      end
      chk("req_seen", {31'd0, req}, 32'd1);
      chk("fetch_addr", addr, exp_addr);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear = 1'b0;
      ack   = 1'b0;
      stall = 1'b0;
      step();
      step();
      chk("rst_req", {31'd0, req}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_iabort", {31'd0, iabort}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_pc", pc_out, 32'd0);
      chk("rst_pc8", pc8_out, 32'd0);
      reset     = 1'b0;
      pend      = 1'b0;
      m_pc      = 32'd0;
      m_t       = cpsr_t;
      m_stopped = 1'b0;
   endtask

   initial begin
      logic [31:0] s_ins, s_pc, s_pc8;
      int unsigned k;
      cpsr_t = 1'b0; clear = 1'b0; clear_pc = '0; stall = 1'b0;
      ack = 1'b0; fabort = 1'b0; fdata = '0; reset = 1'b1;
      pend = 1'b0; wcnt = 0; lat_lo = 0; lat_hi = 2; stall_pct = 0;
      abort_en = 1'b0; abort_addr = 32'h0000_0040;
      m_pc = '0; m_t = 1'b0; m_stopped = 1'b0;

      // ARM stream out of reset
      do_reset();
      wait_req(32'h0000_0000);
      run_entries(2, 100);

      // Thumb word at 0x100, held under stall between its two halves
      redirect(32'h0000_0100, 1'b1);
      k = 0;
      while (!valid && k < 50) begin
         drive_cycle(1'b1);
         k++;
      end
      chk("thumb_first_valid", {31'd0, valid}, 32'd1);
      s_ins = instr; s_pc = pc_out; s_pc8 = pc8_out;
      stall_pct = 100;
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b1);
         chk("stall_instr", instr, s_ins);
         chk("stall_pc", pc_out, s_pc);
         chk("stall_pc8", pc8_out, s_pc8);
         chk("stall_valid", {31'd0, valid}, 32'd1);
      end
      stall_pct = 0;
      run_entries(3, 100);

      // Thumb redirect to an odd halfword
      redirect(32'h0000_0202, 1'b1);
      wait_req(32'h0000_0200);
      run_entries(1, 100);
      wait_req(32'h0000_0204);

      // ARM redirect with bit 1 set is word-aligned
      redirect(32'h0000_0206, 1'b0);
      run_entries(2, 100);

      // Clear with a request in flight: the late ack must be dropped
      lat_lo = 3; lat_hi = 3;
      redirect(32'h0000_0300, 1'b0);
      wait_req(32'h0000_0300);
      drive_cycle(1'b1);
      redirect(32'h0000_0400, 1'b0);
      chk("drain_req_low", {31'd0, req}, 32'd0);
      k = 0;
      while (!req && k < 20) begin
         chk("drain_valid_low", {31'd0, valid}, 32'd0);
         drive_cycle(1'b1);
         k++;
      end
      chk("refetch_addr", addr, 32'h0000_0400);
      run_entries(3, 100);
      lat_lo = 0; lat_hi = 2;

      // Aborted word stops fetching until the next clear
      abort_en = 1'b1;
      redirect(32'h0000_0040, 1'b0);
      run_entries(1, 100);
      chk("abort_stopped", {31'd0, m_stopped}, 32'd1);
      stall_pct = 40;
      for (int i = 0; i < 12; i++) begin
         chk("no_req_after_abort", {31'd0, req}, 32'd0);
         drive_cycle(1'b1);
      end
      stall_pct = 0;
      drive_cycle(1'b1);
      chk("valid_dropped_after_abort", {31'd0, valid}, 32'd0);
      abort_en = 1'b0;

      // Thumb pc wrap across 2^32
      redirect(32'hFFFF_FFFC, 1'b1);
      run_entries(4, 100);

      // Randomized redirects, modes, latencies and stalls
      stall_pct = 30;
      for (int r = 0; r < 30; r++) begin
         lat_lo = 0;
         lat_hi = $urandom_range(4, 0);
         redirect($urandom & 32'h0000_FFFF, 1'($urandom_range(1, 0)));
         run_entries($urandom_range(8, 1), 300);
      end

      // Reset while a request is in flight
      stall_pct = 0;
      lat_lo = 3; lat_hi = 3;
      redirect(32'h0000_0800, 1'b1);
      wait_req(32'h0000_0800);
      drive_cycle(1'b1);
      cpsr_t = 1'b0;
      do_reset();
      lat_lo = 0; lat_hi = 2;
      wait_req(32'h0000_0000);
      run_entries(2, 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
